// File: rtl/mul_share_arb.sv
// mul_share_arb
// Shares one external combinational 4x4 multiplier between two requesters.
// Requests are granted round-robin. The operands are held on the multiplier
// for SETTLE_CYCLES cycles. The product is then captured and returned with
// the requester ID over a backpressured response channel.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req0_valid/_a/_b      : requester 0 operand handshake (in)
//   req0_ready            : requester 0 accepted this cycle (out)
//   req1_*                : same for requester 1
//   mul_a, mul_b          : operands driven to the shared multiplier (out)
//   mul_p                 : product from the shared multiplier (in)
//   rsp_valid/_p/_id      : response channel (out)
//   rsp_ready             : response consumer accepts (in)
//   busy                  : high whenever the FSM is not idle (out)
//   op_count              : completed responses, wraps at 256 (out)
module mul_share_arb #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  output logic       rsp_valid,
  output logic [7:0] rsp_p,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  // Requester granted most recently; it doubles as the ID of the in-flight op.
  logic       last_grant_q, last_grant_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_p_q, rsp_p_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] op_count_q, op_count_d;

  logic       grant_vld_s;
  logic       grant_id_s;
  logic       accept_s;

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // rst_n gates the readys so nothing looks accepted while reset is held.
  assign accept_s   = rst_n && (state_q == ST_IDLE) && grant_vld_s;
  assign req0_ready = accept_s && !grant_id_s;
  assign req1_ready = accept_s && grant_id_s;

  // FSM next-state and datapath next-values.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_p_d      = rsp_p_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_a_d       = grant_id_s ? req1_a : req0_a;
          op_b_d       = grant_id_s ? req1_b : req0_b;
          last_grant_d = grant_id_s;
          cnt_d        = CNT_LOAD;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // The count reaching zero means the operands have been stable
        // for SETTLE_CYCLES full cycles, so mul_p is safe to sample.
        if (cnt_q == 4'd0) begin
          rsp_p_d     = mul_p;
          rsp_id_d    = last_grant_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_p_q      <= 8'd0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_p_q      <= rsp_p_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  // The operand registers stay on the multiplier in IDLE as well.
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Testbench for mul_share_arb: directed scenarios plus randomized traffic.
// A transaction-level reference model predicts grants, products, latency
// and the completion count. Stimulus and checking are decoupled through
// a scoreboard queue.
module tb_mul_share_arb;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic [7:0] mul_p, rsp_p, op_count;
  logic       rsp_valid, rsp_id, rsp_ready, busy;

  // Shared multiplier: a plain unsigned multiply.
  assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

  mul_share_arb #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .op_count(op_count)
  );

  // Extra instances for the latency extremes.
  logic       x_v;
  logic [3:0] x_a, x_b;
  logic       o1_r0, o1_r1, o1_rv, o1_id, o1_busy;
  logic [3:0] o1_ma, o1_mb;
  logic [7:0] o1_mp, o1_p, o1_cnt;
  logic       o15_r0, o15_r1, o15_rv, o15_id, o15_busy;
  logic [3:0] o15_ma, o15_mb;
  logic [7:0] o15_mp, o15_p, o15_cnt;

  assign o1_mp  = {4'd0, o1_ma} * {4'd0, o1_mb};
  assign o15_mp = {4'd0, o15_ma} * {4'd0, o15_mb};

  mul_share_arb #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x_v), .req0_a(x_a), .req0_b(x_b), .req0_ready(o1_r0),
    .req1_valid(1'b0), .req1_a(4'd0), .req1_b(4'd0), .req1_ready(o1_r1),
    .mul_a(o1_ma), .mul_b(o1_mb), .mul_p(o1_mp),
    .rsp_valid(o1_rv), .rsp_p(o1_p), .rsp_id(o1_id), .rsp_ready(1'b1),
    .busy(o1_busy), .op_count(o1_cnt)
  );

  mul_share_arb #(.SETTLE_CYCLES(15)) u15 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x_v), .req0_a(x_a), .req0_b(x_b), .req0_ready(o15_r0),
    .req1_valid(1'b0), .req1_a(4'd0), .req1_b(4'd0), .req1_ready(o15_r1),
    .mul_a(o15_ma), .mul_b(o15_mb), .mul_p(o15_mp),
    .rsp_valid(o15_rv), .rsp_p(o15_p), .rsp_id(o15_id), .rsp_ready(1'b1),
    .busy(o15_busy), .op_count(o15_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic id;
    int   a;
    int   b;
    int   acc_cyc;
  } txn_t;

  txn_t sb[$];
  int   id_log[$];
  int   cyc = 0;
  int   m_count = 0;
  int   hs_cnt = 0;
  int   m_a = 0, m_b = 0;
  logic m_busy = 1'b0;
  logic m_last = 1'b1;
  logic prev_rv = 1'b0;
  logic seen0 = 1'b0, seen1 = 1'b0;
  logic m_gid;
  int   m_exp_rdy;

  always @(posedge clk) cyc++;

  // Monitor: predicts each cycle's grant and checks every response presented.
  always @(negedge clk) begin
    seen0 = req0_ready;
    seen1 = req1_ready;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_readys", {req1_ready, req0_ready}, 0);
      sb.delete();
      m_busy = 1'b0; m_last = 1'b1; m_a = 0; m_b = 0;
      m_count = 0; hs_cnt = 0; prev_rv = 1'b0;
    end else begin
      chk("busy", busy, m_busy);
      chk("op_count", op_count, m_count);
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      m_exp_rdy = 0;
      m_gid = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        m_gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_exp_rdy = m_gid ? 2 : 1;
      end
      chk("ready", {req1_ready, req0_ready}, m_exp_rdy);
      if (m_exp_rdy != 0) begin
        sb.push_back('{m_gid, m_gid ? int'(req1_a) : int'(req0_a),
                       m_gid ? int'(req1_b) : int'(req0_b), cyc});
        m_busy = 1'b1;
        m_last = m_gid;
        m_a = m_gid ? int'(req1_a) : int'(req0_a);
        m_b = m_gid ? int'(req1_b) : int'(req0_b);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_p", rsp_p, sb[0].a * sb[0].b);
          chk("rsp_id", rsp_id, sb[0].id);
          if (!prev_rv) chk("latency", cyc - sb[0].acc_cyc, S + 1);
          if (rsp_ready) begin
            id_log.push_back(sb[0].id);
            void'(sb.pop_front());
            m_busy = 1'b0;
            m_count = (m_count + 1) % 256;
            hs_cnt++;
          end
        end
      end
      prev_rv = rsp_valid && !rsp_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b);
    bit got = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_hs(output int p, output int id);
    bit got = 1'b0;
    p = -1; id = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin p = rsp_p; id = rsp_id; got = 1'b1; break; end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  int p, id, base, k, l1, l15, p1, p15;
  bit got;
  logic [3:0] ta, tb_;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    x_v = 1'b0; x_a = 4'd0; x_b = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request and the operand extremes.
    rsp_ready = 1'b1;
    issue(1'b0, 4'd7, 4'd9);
    wait_hs(p, id);
    chk("t1_p", p, 8'h3F); chk("t1_id", id, 0); chk("t1_count", op_count, 1);
    issue(1'b1, 4'd15, 4'd15);
    wait_hs(p, id);
    chk("t2_p", p, 8'hE1); chk("t2_id", id, 1);
    issue(1'b0, 4'd0, 4'd13);
    wait_hs(p, id);
    chk("t3_p", p, 8'h00); chk("t3_id", id, 0);

    // Both requesters held valid from reset: strict alternation.
    do_reset();
    base = id_log.size();
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd7;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (id_log.size() >= base + 4) break;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", id_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < id_log.size()) chk("rr_order", id_log[base + i], i % 2);

    // Backpressure: response held 5 cycles while requester 0 waits.
    rsp_ready = 1'b0;
    issue(1'b1, 4'd9, 4'd4);
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    got = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("bp_rsp_seen", got, 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    got = 1'b0;
    for (k = 1; k < 10; k++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1'b1; break; end
    end
    chk("bp_reaccept_cycles", got ? k : -1, 2);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_hs(p, id);
    chk("bp_next_p", p, 6);

    // Reset in the second SETTLE cycle; readys stay low while reset is held.
    issue(1'b0, 4'd5, 4'd5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got = 1'b0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin got = 1'b1; break; end
    end
    chk("post_rst_grant0", got ? int'(req0_ready) : -1, 1);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_hs(p, id);
    chk("post_rst_p", p, 2); chk("post_rst_id", id, 0);

    // Randomized traffic with random backpressure and abandoned requests.
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (seen0) req0_valid = 1'b0;
      else if (req0_valid && $urandom_range(0, 9) == 0) req0_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom);
      end
      if (seen1) req1_valid = 1'b0;
      else if (req1_valid && $urandom_range(0, 9) == 0) req1_valid = 1'b0;
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 257 back-to-back operations: op_count wraps to 1.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (hs_cnt >= 257) break;
      @(posedge clk); #1;
      if (seen0) begin req0_a = 4'($urandom); req0_b = 4'($urandom); end
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    chk("wrap_hs", hs_cnt, 257);
    chk("wrap_op_count", op_count, 8'h01);

    // Latency extremes on SETTLE_CYCLES = 1 and 15.
    for (int r = 0; r < 2; r++) begin
      ta = (r == 0) ? 4'd15 : 4'd11;
      tb_ = (r == 0) ? 4'd15 : 4'd6;
      x_v = 1'b1; x_a = ta; x_b = tb_;
      got = 1'b0;
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (o1_r0 && o15_r0) begin got = 1'b1; break; end
      end
      chk("lat_accept", got, 1);
      @(posedge clk); #1 x_v = 1'b0;
      l1 = -1; l15 = -1; p1 = -1; p15 = -1;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (o1_rv && l1 < 0) begin l1 = n; p1 = o1_p; end
        if (o15_rv && l15 < 0) begin l15 = n; p15 = o15_p; end
      end
      chk("lat_s1", l1, 2);
      chk("lat_s15", l15, 16);
      chk("lat_s1_p", p1, int'(ta) * int'(tb_));
      chk("lat_s15_p", p15, int'(ta) * int'(tb_));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
